// File: rtl/sd_cmd_arbiter.sv
// Shares one SD command engine between software commands and Auto CMD12.
// Auto CMD12 wins arbitration, and a watchdog bounds the wait for a response.
module sd_cmd_arbiter #(
  parameter int unsigned WatchdogCycles = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sw_req_i,
  input  logic [5:0]  sw_cmd_index_i,
  input  logic [31:0] sw_argument_i,
  input  logic [1:0]  sw_rsp_type_i,
  input  logic        auto_req_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_argument_o,
  output logic [1:0]  cmd_rsp_type_o,
  input  logic        cmd_done_i,
  input  logic        rsp_done_i,
  input  logic        rsp_err_i,
  output logic        cmd_inhibit_o,
  output logic        auto_cmd12_active_o,
  output logic        sw_cmd_complete_o,
  output logic        sw_cmd_err_o,
  output logic        sw_req_dropped_o,
  output logic        auto_cmd12_done_o,
  output logic        auto_cmd12_err_o
);

  localparam int unsigned    WdW    = $clog2(WatchdogCycles);
  localparam logic [WdW-1:0] WdLast = WdW'(WatchdogCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SENDING,
    S_WAIT_RSP,
    S_FINISH
  } state_e;

  typedef enum logic {
    OWN_SW,
    OWN_AUTO
  } owner_e;

  state_e         state_q, state_d;
  owner_e         owner_q, owner_d;
  logic           sw_pend_q, sw_pend_d;
  logic           auto_pend_q, auto_pend_d;
  logic           err_q, err_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic [5:0]     cmd_index_q, cmd_index_d;
  logic [31:0]    cmd_arg_q, cmd_arg_d;
  logic [1:0]     cmd_rsp_q, cmd_rsp_d;

  logic [5:0]     sw_index_q;
  logic [31:0]    sw_arg_q;
  logic [1:0]     sw_rsp_q;

  logic           sw_accept;
  logic           auto_accept;
  logic           busy;

  assign busy                = (state_q != S_IDLE);
  assign cmd_inhibit_o       = sw_pend_q | (busy & (owner_q == OWN_SW));
  assign auto_cmd12_active_o = auto_pend_q | (busy & (owner_q == OWN_AUTO));
  assign sw_accept           = sw_req_i & ~cmd_inhibit_o;
  assign sw_req_dropped_o    = sw_req_i & cmd_inhibit_o;
  // A CMD12 already pending or in flight absorbs further requests.
  assign auto_accept         = auto_req_i & ~auto_pend_q & ~(busy & (owner_q == OWN_AUTO));

  assign cmd_index_o    = cmd_index_q;
  assign cmd_argument_o = cmd_arg_q;
  assign cmd_rsp_type_o = cmd_rsp_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d           = state_q;
    owner_d           = owner_q;
    sw_pend_d         = sw_pend_q;
    auto_pend_d       = auto_pend_q;
    err_d             = err_q;
    wd_d              = '0;
    cmd_index_d       = cmd_index_q;
    cmd_arg_d         = cmd_arg_q;
    cmd_rsp_d         = cmd_rsp_q;
    cmd_valid_o       = 1'b0;
    sw_cmd_complete_o = 1'b0;
    sw_cmd_err_o      = 1'b0;
    auto_cmd12_done_o = 1'b0;
    auto_cmd12_err_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (auto_pend_q) begin
          owner_d     = OWN_AUTO;
          cmd_index_d = 6'd12;
          cmd_arg_d   = 32'd0;
          cmd_rsp_d   = 2'b11;
          auto_pend_d = 1'b0;
          state_d     = S_ISSUE;
        end else if (sw_pend_q) begin
          owner_d     = OWN_SW;
          cmd_index_d = sw_index_q;
          cmd_arg_d   = sw_arg_q;
          cmd_rsp_d   = sw_rsp_q;
          sw_pend_d   = 1'b0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i) state_d = S_SENDING;
      end
      S_SENDING: begin
        if (cmd_done_i) state_d = (cmd_rsp_q == 2'b00) ? S_FINISH : S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        // A response on the terminal watchdog cycle still takes precedence.
        if (rsp_done_i) begin
          err_d   = rsp_err_i;
          state_d = S_FINISH;
        end else if (wd_q == WdLast) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_FINISH: begin
        if (owner_q == OWN_AUTO) begin
          auto_cmd12_done_o = 1'b1;
          auto_cmd12_err_o  = err_q;
        end else begin
          sw_cmd_complete_o = 1'b1;
          sw_cmd_err_o      = err_q;
        end
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (sw_accept)   sw_pend_d   = 1'b1;
    if (auto_accept) auto_pend_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_SW;
      sw_pend_q   <= 1'b0;
      auto_pend_q <= 1'b0;
      err_q       <= 1'b0;
      wd_q        <= '0;
      cmd_index_q <= '0;
      cmd_arg_q   <= '0;
      cmd_rsp_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      state_q     <= state_d;
      owner_q     <= owner_d;
      sw_pend_q   <= sw_pend_d;
      auto_pend_q <= auto_pend_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q   <= cmd_arg_d;
      cmd_rsp_q   <= cmd_rsp_d;
    end
  end

  // NOTE: the slot payload has no reset; sw_pend_q alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (sw_accept) begin
      sw_index_q <= sw_cmd_index_i;
      sw_arg_q   <= sw_argument_i;
      sw_rsp_q   <= sw_rsp_type_i;
    end
  end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Self-checking bench for sd_cmd_arbiter: directed scenarios plus randomized
// command mixes scored against an order/pulse-count model.
module tb_sd_cmd_arbiter;

  localparam int WD = 16;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [1:0]  rsp;
  } cmd_t;

  typedef enum int {POKE_NONE, POKE_SW, POKE_AUTO, POKE_AUTO_AT_DONE} poke_e;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw_req = 1'b0;
  logic [5:0]  sw_idx = '0;
  logic [31:0] sw_arg = '0;
  logic [1:0]  sw_rsp = '0;
  logic        auto_req = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_done = 1'b0;
  logic        rsp_done = 1'b0;
  logic        rsp_err = 1'b0;

  logic        cmd_valid_o, cmd_inhibit_o, auto_cmd12_active_o;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_argument_o;
  logic [1:0]  cmd_rsp_type_o;
  logic        sw_cmd_complete_o, sw_cmd_err_o, sw_req_dropped_o;
  logic        auto_cmd12_done_o, auto_cmd12_err_o;
  logic [47:0] all_outs;

  int   pass_n = 0;
  int   total_n = 0;
  int   sw_done_n = 0, sw_err_n = 0, au_done_n = 0, au_err_n = 0;
  int   bad_n = 0, timeout_n = 0, wd_lat = 0;
  bit   dropped_seen = 1'b0;
  cmd_t issued_q[$];
  cmd_t cmd12;

  sd_cmd_arbiter #(.WatchdogCycles(WD)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .sw_req_i           (sw_req),
    .sw_cmd_index_i     (sw_idx),
    .sw_argument_i      (sw_arg),
    .sw_rsp_type_i      (sw_rsp),
    .auto_req_i         (auto_req),
    .cmd_valid_o        (cmd_valid_o),
    .cmd_ready_i        (cmd_ready),
    .cmd_index_o        (cmd_index_o),
    .cmd_argument_o     (cmd_argument_o),
    .cmd_rsp_type_o     (cmd_rsp_type_o),
    .cmd_done_i         (cmd_done),
    .rsp_done_i         (rsp_done),
    .rsp_err_i          (rsp_err),
    .cmd_inhibit_o      (cmd_inhibit_o),
    .auto_cmd12_active_o(auto_cmd12_active_o),
    .sw_cmd_complete_o  (sw_cmd_complete_o),
    .sw_cmd_err_o       (sw_cmd_err_o),
    .sw_req_dropped_o   (sw_req_dropped_o),
    .auto_cmd12_done_o  (auto_cmd12_done_o),
    .auto_cmd12_err_o   (auto_cmd12_err_o)
  );

  assign all_outs = {cmd_valid_o, cmd_index_o, cmd_argument_o, cmd_rsp_type_o, cmd_inhibit_o,
                     auto_cmd12_active_o, sw_cmd_complete_o, sw_cmd_err_o, sw_req_dropped_o,
                     auto_cmd12_done_o, auto_cmd12_err_o};

  always #5 clk = ~clk;

  // Pulse counters and the log of accepted commands, sampled on the falling edge.
  always @(negedge clk) begin
    if (sw_cmd_complete_o) sw_done_n++;
    if (sw_cmd_err_o)      sw_err_n++;
    if (auto_cmd12_done_o) au_done_n++;
    if (auto_cmd12_err_o)  au_err_n++;
    if (cmd_valid_o && cmd_ready) issued_q.push_back({cmd_index_o, cmd_argument_o, cmd_rsp_type_o});
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // Start of a cycle: after the edge, strobes return to zero.
  task automatic cyc();
    @(posedge clk);
    #2;
    sw_req    = 1'b0;
    auto_req  = 1'b0;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    rsp_done  = 1'b0;
    rsp_err   = 1'b0;
  endtask

  // Plays the command engine for one expected command; ends in the FINISH cycle.
  task automatic serve(input cmd_t c, input bit is_auto, input int rdy_dly, input int done_dly,
                       input int rsp_dly, input bit err, input poke_e poke);
    int n;
    bit exp_err;
    n = 0;
    while (!cmd_valid_o) begin
      if (n == 40) begin timeout_n++; return; end
      cyc(); #1; n++;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      if (!cmd_valid_o || ({cmd_index_o, cmd_argument_o, cmd_rsp_type_o} !== c)) bad_n++;
      if (i == rdy_dly) cmd_ready = 1'b1;
      cyc(); #1;
    end
    if (cmd_valid_o) bad_n++;
    for (int i = 0; i < done_dly; i++) begin
      rsp_done = 1'b1;
      rsp_err  = 1'b1;
      cyc(); #1;
    end
    cmd_done = 1'b1;
    if (poke == POKE_AUTO_AT_DONE) auto_req = 1'b1;
    cyc(); #1;
    exp_err = 1'b0;
    if (c.rsp != 2'b00) begin
      for (n = 0; n < ((rsp_dly < 0) ? 100 : rsp_dly); n++) begin
        if (n == 0 && poke == POKE_SW) begin
          sw_req = 1'b1; sw_idx = 6'd33; sw_arg = $urandom; #1;
          dropped_seen = sw_req_dropped_o;
        end
        if (n == 0 && poke == POKE_AUTO) auto_req = 1'b1;
        if (rsp_dly < 0 && (is_auto ? auto_cmd12_done_o : sw_cmd_complete_o)) break;
        cyc(); #1;
      end
      if (rsp_dly < 0) begin
        wd_lat  = n;
        exp_err = 1'b1;
      end else begin
        rsp_done = 1'b1;
        rsp_err  = err;
        exp_err  = err;
        cyc(); #1;
      end
    end
    if (is_auto) begin
      if (auto_cmd12_done_o !== 1'b1 || auto_cmd12_err_o !== exp_err || sw_cmd_complete_o !== 1'b0) bad_n++;
    end else begin
      if (sw_cmd_complete_o !== 1'b1 || sw_cmd_err_o !== exp_err || auto_cmd12_done_o !== 1'b0) bad_n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc(); #1;
    total_n++;
    if (all_outs !== 48'd0) $display("FAIL reset_outputs: got %h expected 0", all_outs);
    else pass_n++;
    rst = 1'b0;
    cyc(); cyc(); #1;
    total_n++;
    if (all_outs !== 48'd0) $display("FAIL idle_outputs: got %h expected 0", all_outs);
    else pass_n++;
  endtask

  task automatic test_sw_basic();
    int   s_done, s_err, b0;
    cmd_t c;
    c = '{idx: 6'd17, arg: 32'h200, rsp: 2'b10};
    cyc(); #1;
    b0 = bad_n + timeout_n; s_done = sw_done_n; s_err = sw_err_n;
    sw_req = 1'b1; sw_idx = c.idx; sw_arg = c.arg; sw_rsp = c.rsp; #1;
    total_n++;
    if (sw_req_dropped_o !== 1'b0) $display("FAIL sw_basic_accept: dropped got %b expected 0", sw_req_dropped_o);
    else pass_n++;
    cyc(); #1;
    total_n++;
    if ({cmd_valid_o, cmd_inhibit_o} !== 2'b01)
      $display("FAIL sw_basic_slot: valid,inhibit got %b expected 01", {cmd_valid_o, cmd_inhibit_o});
    else pass_n++;
    cyc(); #1;
    total_n++;
    if (cmd_valid_o !== 1'b1) $display("FAIL sw_basic_latency: valid got %b expected 1", cmd_valid_o);
    else pass_n++;
    serve(c, 1'b0, 3, 1, 2, 1'b0, POKE_NONE);
    total_n++;
    if (cmd_inhibit_o !== 1'b1) $display("FAIL sw_basic_inhibit_finish: got %b expected 1", cmd_inhibit_o);
    else pass_n++;
    cyc(); #1;
    total_n++;
    if (cmd_inhibit_o !== 1'b0) $display("FAIL sw_basic_inhibit_fall: got %b expected 0", cmd_inhibit_o);
    else pass_n++;
    total_n++;
    if (sw_done_n - s_done !== 1 || sw_err_n - s_err !== 0)
      $display("FAIL sw_basic_pulses: done %0d err %0d expected 1 0", sw_done_n - s_done, sw_err_n - s_err);
    else pass_n++;
    total_n++;
    if (bad_n + timeout_n - b0 !== 0) $display("FAIL sw_basic_protocol: violations %0d expected 0", bad_n + timeout_n - b0);
    else pass_n++;
  endtask

  task automatic test_simultaneous();
    int   a_done, b0;
    cmd_t c;
    c = '{idx: 6'd18, arg: 32'hCAFE_0001, rsp: 2'b10};
    cyc(); #1;
    issued_q.delete();
    b0 = bad_n + timeout_n; a_done = au_done_n;
    sw_req = 1'b1; sw_idx = c.idx; sw_arg = c.arg; sw_rsp = c.rsp;
    auto_req = 1'b1; #1;
    serve(cmd12, 1'b1, 1, 0, 2, 1'b0, POKE_NONE);
    total_n++;
    if (auto_cmd12_active_o !== 1'b1) $display("FAIL simul_active_finish: got %b expected 1", auto_cmd12_active_o);
    else pass_n++;
    cyc(); #1;
    total_n++;
    if ({auto_cmd12_active_o, cmd_valid_o} !== 2'b00)
      $display("FAIL simul_active_fall: active,valid got %b expected 00", {auto_cmd12_active_o, cmd_valid_o});
    else pass_n++;
    cyc(); #1;
    total_n++;
    if (cmd_valid_o !== 1'b1) $display("FAIL simul_second_issue: valid got %b expected 1", cmd_valid_o);
    else pass_n++;
    serve(c, 1'b0, 0, 0, 1, 1'b0, POKE_NONE);
    cyc(); #1;
    total_n++;
    if (issued_q.size() != 2 || issued_q[0] !== cmd12 || issued_q[1] !== c)
      $display("FAIL simul_order: issued %0d commands, first idx %0d expected 2 commands 12 then 18",
               issued_q.size(), (issued_q.size() > 0) ? int'(issued_q[0].idx) : -1);
    else pass_n++;
    total_n++;
    if (au_done_n - a_done !== 1 || bad_n + timeout_n - b0 !== 0)
      $display("FAIL simul_pulses: auto done %0d violations %0d expected 1 0", au_done_n - a_done, bad_n + timeout_n - b0);
    else pass_n++;
  endtask

  task automatic test_drop_and_coalesce();
    int   a_done, b0;
    cmd_t c;
    c = '{idx: 6'd20, arg: 32'h1234_5678, rsp: 2'b01};
    cyc(); #1;
    issued_q.delete();
    b0 = bad_n + timeout_n;
    dropped_seen = 1'b0;
    sw_req = 1'b1; sw_idx = c.idx; sw_arg = c.arg; sw_rsp = c.rsp; #1;
    serve(c, 1'b0, 1, 1, 3, 1'b1, POKE_SW);
    total_n++;
    if (dropped_seen !== 1'b1) $display("FAIL drop_pulse: got %b expected 1", dropped_seen);
    else pass_n++;
    for (int i = 0; i < 6; i++) begin cyc(); #1; end
    total_n++;
    if (issued_q.size() != 1 || cmd_valid_o !== 1'b0)
      $display("FAIL drop_single_issue: issued %0d valid %b expected 1 0", issued_q.size(), cmd_valid_o);
    else pass_n++;
    issued_q.delete();
    a_done = au_done_n;
    auto_req = 1'b1; #1;
    cyc(); auto_req = 1'b1; #1;
    serve(cmd12, 1'b1, 0, 0, 2, 1'b0, POKE_AUTO);
    for (int i = 0; i < 6; i++) begin cyc(); #1; end
    total_n++;
    if (issued_q.size() != 1 || au_done_n - a_done !== 1 || auto_cmd12_active_o !== 1'b0)
      $display("FAIL coalesce: issued %0d done %0d active %b expected 1 1 0",
               issued_q.size(), au_done_n - a_done, auto_cmd12_active_o);
    else pass_n++;
    total_n++;
    if (bad_n + timeout_n - b0 !== 0) $display("FAIL drop_protocol: violations %0d expected 0", bad_n + timeout_n - b0);
    else pass_n++;
  endtask

  task automatic test_no_rsp();
    int   s_done, s_err, b0;
    cmd_t c;
    c = '{idx: 6'd0, arg: 32'h0, rsp: 2'b00};
    cyc(); #1;
    b0 = bad_n + timeout_n;
    sw_req = 1'b1; sw_idx = c.idx; sw_arg = c.arg; sw_rsp = c.rsp; #1;
    serve(c, 1'b0, 0, 2, 0, 1'b0, POKE_NONE);
    cyc(); #1;
    s_done = sw_done_n; s_err = sw_err_n;
    rsp_done = 1'b1; rsp_err = 1'b1; cmd_done = 1'b1;
    for (int i = 0; i < 4; i++) begin cyc(); #1; end
    total_n++;
    if (sw_done_n != s_done || sw_err_n != s_err || cmd_valid_o !== 1'b0 || cmd_inhibit_o !== 1'b0)
      $display("FAIL stray_rsp_idle: done %0d err %0d valid %b inhibit %b expected 0 0 0 0",
               sw_done_n - s_done, sw_err_n - s_err, cmd_valid_o, cmd_inhibit_o);
    else pass_n++;
    total_n++;
    if (bad_n + timeout_n - b0 !== 0) $display("FAIL no_rsp_protocol: violations %0d expected 0", bad_n + timeout_n - b0);
    else pass_n++;
  endtask

  task automatic test_watchdog();
    int a_done, a_err, b0;
    cyc(); #1;
    b0 = bad_n + timeout_n; a_done = au_done_n; a_err = au_err_n;
    auto_req = 1'b1; #1;
    serve(cmd12, 1'b1, 0, 0, -1, 1'b0, POKE_NONE);
    total_n++;
    if (wd_lat !== WD) $display("FAIL watchdog_latency: got %0d expected %0d", wd_lat, WD);
    else pass_n++;
    cyc(); #1;
    total_n++;
    if (au_done_n - a_done !== 1 || au_err_n - a_err !== 1)
      $display("FAIL watchdog_pulses: done %0d err %0d expected 1 1", au_done_n - a_done, au_err_n - a_err);
    else pass_n++;
    a_done = au_done_n; a_err = au_err_n;
    auto_req = 1'b1; #1;
    serve(cmd12, 1'b1, 0, 0, WD - 1, 1'b0, POKE_NONE);
    cyc(); #1;
    total_n++;
    if (au_done_n - a_done !== 1 || au_err_n - a_err !== 0)
      $display("FAIL watchdog_terminal_rsp: done %0d err %0d expected 1 0", au_done_n - a_done, au_err_n - a_err);
    else pass_n++;
    total_n++;
    if (bad_n + timeout_n - b0 !== 0) $display("FAIL watchdog_protocol: violations %0d expected 0", bad_n + timeout_n - b0);
    else pass_n++;
  endtask

  task automatic test_reset_mid();
    int   n, snap, b0;
    cmd_t c;
    c = '{idx: 6'd9, arg: 32'h0000_0BEE, rsp: 2'b11};
    cyc(); #1;
    b0 = bad_n + timeout_n;
    auto_req = 1'b1; #1;
    n = 0;
    while (!cmd_valid_o && n < 10) begin cyc(); #1; n++; end
    if (!cmd_valid_o) timeout_n++;
    cmd_ready = 1'b1;
    cyc(); cmd_done = 1'b1; #1;
    cyc(); sw_req = 1'b1; sw_idx = 6'd5; sw_arg = 32'h55; sw_rsp = 2'b10; #1;
    total_n++;
    if (sw_req_dropped_o !== 1'b0) $display("FAIL reset_mid_accept: dropped got %b expected 0", sw_req_dropped_o);
    else pass_n++;
    cyc(); #1;
    total_n++;
    if ({cmd_inhibit_o, auto_cmd12_active_o} !== 2'b11)
      $display("FAIL reset_mid_pending: inhibit,active got %b expected 11", {cmd_inhibit_o, auto_cmd12_active_o});
    else pass_n++;
    snap = sw_done_n + au_done_n + sw_err_n + au_err_n;
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    total_n++;
    if (all_outs !== 48'd0) $display("FAIL reset_mid_outputs: got %h expected 0", all_outs);
    else pass_n++;
    for (int i = 0; i < 5; i++) begin cyc(); #1; end
    total_n++;
    if (sw_done_n + au_done_n + sw_err_n + au_err_n != snap || cmd_valid_o !== 1'b0)
      $display("FAIL reset_mid_discard: extra pulses %0d valid %b expected 0 0",
               sw_done_n + au_done_n + sw_err_n + au_err_n - snap, cmd_valid_o);
    else pass_n++;
    sw_req = 1'b1; sw_idx = c.idx; sw_arg = c.arg; sw_rsp = c.rsp; #1;
    cyc(); #1;
    total_n++;
    if (cmd_valid_o !== 1'b0) $display("FAIL reset_mid_early: valid got %b expected 0", cmd_valid_o);
    else pass_n++;
    cyc(); #1;
    total_n++;
    if (cmd_valid_o !== 1'b1) $display("FAIL reset_mid_latency: valid got %b expected 1", cmd_valid_o);
    else pass_n++;
    serve(c, 1'b0, 0, 0, 1, 1'b0, POKE_NONE);
    total_n++;
    if (bad_n + timeout_n - b0 !== 0) $display("FAIL reset_mid_protocol: violations %0d expected 0", bad_n + timeout_n - b0);
    else pass_n++;
  endtask

  // Model: issue order follows arrival (CMD12 first on a tie); each source
  // completes once, with error when its response reports one.
  task automatic test_random();
    int   mode, s_done, s_err, a_done, a_err, b0;
    bit   e_sw, e_au, ok;
    cmd_t c;
    cmd_t exp_q[$];
    b0 = bad_n + timeout_n;
    for (int it = 0; it < 20; it++) begin
      cyc(); #1;
      mode  = $urandom_range(0, 2);
      c.idx = 6'($urandom);
      c.arg = $urandom;
      c.rsp = 2'($urandom);
      e_sw  = 1'($urandom);
      e_au  = 1'($urandom);
      exp_q.delete();
      if (mode == 1) exp_q.push_back(cmd12);
      exp_q.push_back(c);
      if (mode == 2) exp_q.push_back(cmd12);
      issued_q.delete();
      s_done = sw_done_n; s_err = sw_err_n; a_done = au_done_n; a_err = au_err_n;
      sw_req = 1'b1; sw_idx = c.idx; sw_arg = c.arg; sw_rsp = c.rsp;
      if (mode == 1) auto_req = 1'b1;
      #1;
      if (mode == 1) begin
        serve(cmd12, 1'b1, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 6), e_au, POKE_NONE);
        cyc(); #1;
      end
      serve(c, 1'b0, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 6), e_sw,
            (mode == 2) ? POKE_AUTO_AT_DONE : POKE_NONE);
      if (mode == 2) begin
        cyc(); #1;
        serve(cmd12, 1'b1, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 6), e_au, POKE_NONE);
      end
      cyc(); #1;
      ok = (issued_q.size() == exp_q.size());
      for (int i = 0; i < exp_q.size() && ok; i++) if (issued_q[i] !== exp_q[i]) ok = 1'b0;
      total_n++;
      if (!ok) $display("FAIL rand_order it=%0d mode=%0d: issued %0d commands expected %0d",
                        it, mode, issued_q.size(), exp_q.size());
      else pass_n++;
      total_n++;
      if (sw_done_n - s_done !== 1 || sw_err_n - s_err !== int'((c.rsp != 2'b00) && e_sw))
        $display("FAIL rand_sw_pulses it=%0d: done %0d err %0d expected 1 %0d",
                 it, sw_done_n - s_done, sw_err_n - s_err, int'((c.rsp != 2'b00) && e_sw));
      else pass_n++;
      total_n++;
      if (au_done_n - a_done !== int'(mode != 0) || au_err_n - a_err !== int'((mode != 0) && e_au))
        $display("FAIL rand_auto_pulses it=%0d: done %0d err %0d expected %0d %0d", it,
                 au_done_n - a_done, au_err_n - a_err, int'(mode != 0), int'((mode != 0) && e_au));
      else pass_n++;
    end
    total_n++;
    if (bad_n + timeout_n - b0 !== 0) $display("FAIL rand_protocol: violations %0d expected 0", bad_n + timeout_n - b0);
    else pass_n++;
  endtask

  initial begin
    cmd12 = '{idx: 6'd12, arg: 32'd0, rsp: 2'b11};
    test_reset();
    test_sw_basic();
    test_simultaneous();
    test_drop_and_coalesce();
    test_no_rsp();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/sd_cmd_arbiter.md
# sd_cmd_arbiter

Shares the single SD command engine between two requesters: host-software commands (Command register write) and the data path's Auto CMD12 request at end of a multi-block transfer. It latches one pending request per source, grants Auto CMD12 first, and presents one command at a time to the command engine. It then tracks command send and response completion, with a backstop watchdog, and reports per-source completion and error pulses plus Command Inhibit status.

## Interface
- WatchdogCycles, 4096: cycles allowed in WAIT_RSP before forced error completion; must be ≥ 2.
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- sw_req_i  in  1  one-cycle strobe: software wrote the command index
- sw_cmd_index_i  in  6  software command index, sampled with sw_req_i
- sw_argument_i  in  32  software argument, sampled with sw_req_i
- sw_rsp_type_i  in  2  00 none, 01 136-bit, 10 48-bit, 11 48-bit with busy; sampled with sw_req_i
- auto_req_i  in  1  one-cycle strobe from the data path requesting CMD12
- cmd_valid_o  out  1  command offered to the command engine
- cmd_ready_i  in  1  command engine accepts the command
- cmd_index_o  out  6  index of the granted command
- cmd_argument_o  out  32  argument of the granted command
- cmd_rsp_type_o  out  2  response type of the granted command
- cmd_done_i  in  1  strobe: command fully sent on the CMD line
- rsp_done_i  in  1  strobe: response received or engine-side timeout
- rsp_err_i  in  1  qualifies rsp_done_i: CRC, end-bit, index or timeout error
- cmd_inhibit_o  out  1  software must not issue a command
- auto_cmd12_active_o  out  1  Auto CMD12 pending or in flight
- sw_cmd_complete_o  out  1  pulse: software command finished
- sw_cmd_err_o  out  1  pulse, with sw_cmd_complete_o: finished with error
- sw_req_dropped_o  out  1  pulse: sw_req_i rejected because the arbiter was busy
- auto_cmd12_done_o  out  1  pulse: Auto CMD12 finished
- auto_cmd12_err_o  out  1  pulse, with auto_cmd12_done_o: finished with error

## Operation
- Pending slots:
  - sw_pend, with registered index, argument and rsp_type.
  - auto_pend.
- sw_req_i accepted only when cmd_inhibit_o=0. Otherwise: no state change, sw_req_dropped_o=1 in the same cycle.
- auto_req_i sets auto_pend unless auto_pend is already set or owner=AUTO and state≠IDLE. In that case it is coalesced and ignored. It is accepted in every state, including while a software command is active.
- Owner register: SW or AUTO. The granted command fields live in an output register, stable from ISSUE through FINISH.
- States:
  - IDLE: if auto_pend, grant AUTO with fields index 12, argument 0, rsp 11, and clear auto_pend. Else if sw_pend, grant SW with its fields and clear sw_pend. Both cases go to ISSUE.
  - ISSUE: cmd_valid_o=1. On cmd_ready_i go to SENDING.
  - SENDING: on cmd_done_i, go to FINISH if rsp_type=00, else WAIT_RSP. rsp_done_i is ignored here.
  - WAIT_RSP: the watchdog counter counts from 0.
    - On rsp_done_i: latch err=rsp_err_i and go to FINISH.
    - Else when the counter = WatchdogCycles-1: err=1, go to FINISH.
  - FINISH: one cycle. Pulse the owner's done output, plus its err output if err. Clear err and go to IDLE.
- cmd_inhibit_o = sw_pend | (state≠IDLE & owner=SW).
- auto_cmd12_active_o = auto_pend | (state≠IDLE & owner=AUTO).
- Strobes cmd_done_i and rsp_done_i outside their consuming states are ignored.

## Timing
- Reset values:
  - state IDLE, both slots clear, owner SW, err 0, watchdog 0.
  - All outputs 0, including the cmd_* fields.
- Request accepted at edge k: slot set from k+1, ISSUE and cmd_valid_o=1 from k+2.
- Handshake:
  - cmd_valid_o stays high, with fields unchanged, until the cycle with cmd_ready_i=1. It is low the cycle after.
  - cmd_ready_i is don't-care while cmd_valid_o=0.
- FINISH is exactly one cycle after the consuming strobe. A pending request enters ISSUE two cycles after FINISH.
- Simultaneous sw_req_i and auto_req_i in IDLE with nothing pending: both latched, AUTO served first, SW next.
- Watchdog: WAIT_RSP entered at cycle t with no rsp_done_i → FINISH at t+WatchdogCycles.
- rsp_done_i arriving on the watchdog terminal cycle: rsp_done_i wins and err=rsp_err_i.
- Reset mid-operation: next cycle, all outputs are at reset values and no pulses are emitted. In-flight and pending commands are discarded.

## Test plan
- SW command: index 17, argument 0x200, rsp 10; cmd_ready_i held low for 3 cycles, then cmd_done_i, then rsp_done_i with rsp_err_i=0.
  - Fields stay stable while cmd_valid_o is high.
  - One sw_cmd_complete_o pulse, sw_cmd_err_o=0.
  - cmd_inhibit_o falls the cycle after FINISH.
- sw_req_i (index 18) and auto_req_i in the same IDLE cycle.
  - CMD12 issued first: index 12, argument 0, rsp 11.
  - auto_cmd12_done_o pulse, then index 18 issued.
  - auto_cmd12_active_o falls after the CMD12 FINISH.
- sw_req_i while in WAIT_RSP of a SW command.
  - sw_req_dropped_o pulse in the same cycle.
  - Exactly one command issued. A repeated auto_req_i during an Auto CMD12 yields one CMD12 only.
- rsp_type 00 command: FINISH the cycle after cmd_done_i, with no rsp_done_i needed. A stray rsp_done_i in IDLE has no effect.
- WatchdogCycles=16 and rsp_done_i never asserted: auto_cmd12_done_o and auto_cmd12_err_o pulse 16 cycles after WAIT_RSP entry.
- rst_i asserted in WAIT_RSP with sw_pend set.
  - All outputs 0 the following cycle, with no completion pulse.
  - A new sw_req_i afterwards issues normally with +2 latency.
